// File: rtl/tdc_enable_register_responder_pkg.sv
// Shared types and constants for the TDC enable register responder.
// Includes the handshake state encoding, register addresses and status-word layout.
package tdc_enable_register_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NOTIFY,
    ST_WAIT_REQ,
    ST_ACK,
    ST_WAIT_RELEASE
  } resp_state_e;

  localparam logic ADDR_MASK   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_RETRY_LSB = 24;
  localparam int STAT_RETRY_MSB = 31;
  localparam int STAT_DIRTY     = 16;

  localparam int         RETRY_W   = 8;
  localparam logic [7:0] RETRY_MAX = 8'hFF;

  // Ones in the low n bit positions; used to strip writes to channels that do not exist.
  function automatic logic [31:0] channel_mask(input int n);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/tdc_enable_timeout_counter.sv
// Counts cycles spent waiting for the controller's request.
// The terminal count is asserted at TIMEOUT_CYCLES-1.
module tdc_enable_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)              cnt_d = '0;
    else if (enable_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tdc_enable_register_responder.sv
// Register-side end of the TDC enable handshake: holds the software mask, announces
// changes with channel_changed and answers controller reads with a snapshot and read_ack.
module tdc_enable_register_responder
  import tdc_enable_register_responder_pkg::*;
#(
  parameter int CHANNEL_COUNT  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cfg_write_i,
  input  logic                     cfg_addr_i,
  input  logic [31:0]              cfg_wdata_i,
  output logic [31:0]              cfg_rdata_o,
  input  logic                     read_active_channel_i,
  input  logic [CHANNEL_COUNT-1:0] enable_channels_i,
  output logic [31:0]              activate_channels_o,
  output logic                     channel_changed_o,
  output logic                     read_ack_o
);

  localparam logic [31:0] CH_MASK = channel_mask(CHANNEL_COUNT);

  resp_state_e        state_q, state_d;
  logic [31:0]        pending_q, pending_d;
  logic [31:0]        act_q, act_d;
  logic               dirty_q, dirty_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               mask_wr;
  logic               tmo_clear, tmo_en, tmo_tc;
  logic [31:0]        status;

  tdc_enable_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (tmo_clear),
    .enable_i(tmo_en),
    .tc_o    (tmo_tc)
  );

  // FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dirty_q)                    state_d = ST_NOTIFY;
        else if (read_active_channel_i) state_d = ST_ACK;
      end
      ST_NOTIFY:   state_d = ST_WAIT_REQ;
      ST_WAIT_REQ: begin
        if (read_active_channel_i) state_d = ST_ACK;
        else if (tmo_tc)           state_d = ST_NOTIFY;
      end
      ST_ACK:          state_d = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (!read_active_channel_i) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    channel_changed_o = 1'b0;
    read_ack_o        = 1'b0;
    tmo_clear         = 1'b0;
    tmo_en            = 1'b0;
    case (state_q)
      ST_NOTIFY: begin
        channel_changed_o = 1'b1;
        tmo_clear         = 1'b1;
      end
      ST_WAIT_REQ: tmo_en     = 1'b1;
      ST_ACK:      read_ack_o = 1'b1;
      default: ;
    endcase
  end

  assign mask_wr = cfg_write_i && (cfg_addr_i == ADDR_MASK);

  // Snapshot uses pending_d so a write landing with the request is the value delivered.
  always_comb begin
    pending_d = mask_wr ? (cfg_wdata_i & CH_MASK) : pending_q;
    dirty_d   = dirty_q;
    if (mask_wr)               dirty_d = 1'b1;
    else if (state_q == ST_ACK) dirty_d = 1'b0;
    act_d = act_q;
    if (state_d == ST_ACK && state_q != ST_ACK) act_d = pending_d;
    retry_d = retry_q;
    if (state_q == ST_WAIT_REQ && !read_active_channel_i && tmo_tc && retry_q != RETRY_MAX)
      retry_d = retry_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= '0;
      act_q     <= '0;
      dirty_q   <= 1'b0;
      retry_q   <= '0;
    end else begin
      pending_q <= pending_d;
      act_q     <= act_d;
      dirty_q   <= dirty_d;
      retry_q   <= retry_d;
    end
  end

  assign activate_channels_o = act_q;

  always_comb begin
    status                                = '0;
    status[STAT_RETRY_MSB:STAT_RETRY_LSB] = retry_q;
    status[STAT_DIRTY]                    = dirty_q;
    status[CHANNEL_COUNT-1:0]             = enable_channels_i;
    cfg_rdata_o = (cfg_addr_i == ADDR_STATUS) ? status : pending_q;
  end

endmodule

// File: tb/tb_tdc_enable_register_responder.sv
// Directed bench for the TDC enable register responder with a per-cycle reference model.
module tb_tdc_enable_register_responder;

  localparam int          CH     = 2;
  localparam int          TMO    = 4;
  localparam logic [31:0] CHMASK = (32'd1 << CH) - 32'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_write = 1'b0;
  logic          cfg_addr = 1'b0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          req = 1'b0;
  logic [CH-1:0] enable_ch = 2'b10;
  logic [31:0]   act;
  logic          cc, ack;

  int checks = 0;
  int errors = 0;
  int cc_seen = 0;
  int ack_seen = 0;

  tdc_enable_register_responder #(
    .CHANNEL_COUNT (CH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .cfg_write_i          (cfg_write),
    .cfg_addr_i           (cfg_addr),
    .cfg_wdata_i          (cfg_wdata),
    .cfg_rdata_o          (cfg_rdata),
    .read_active_channel_i(req),
    .enable_channels_i    (enable_ch),
    .activate_channels_o  (act),
    .channel_changed_o    (cc),
    .read_ack_o           (ack)
  );

  always #5 clk = ~clk;

  // Model: which part of the handshake the cycle is in, plus register contents.
  bit          m_cc, m_ack, m_await, m_held, m_dirty;
  int          m_since, m_retry;
  logic [31:0] m_pend, m_snap;

  task automatic model_reset();
    m_cc = 0; m_ack = 0; m_await = 0; m_held = 0; m_dirty = 0;
    m_since = 0; m_retry = 0; m_pend = '0; m_snap = '0;
  endtask

  task automatic model_step();
    bit wr, n_cc, n_ack, n_await, n_held, n_dirty;
    logic [31:0] n_pend;
    wr = cfg_write && !cfg_addr;
    n_pend = wr ? (cfg_wdata & CHMASK) : m_pend;
    n_dirty = wr ? 1'b1 : (m_ack ? 1'b0 : m_dirty);
    n_cc = 0; n_ack = 0; n_await = 0; n_held = 0;
    if (m_cc) begin
      n_await = 1; m_since = 1;
    end else if (m_await) begin
      if (req) n_ack = 1;
      else if (m_since == TMO) begin
        n_cc = 1;
        if (m_retry < 255) m_retry++;
      end else begin
        n_await = 1; m_since++;
      end
    end else if (m_ack) n_held = 1;
    else if (m_held) n_held = req;
    else if (m_dirty) n_cc = 1;
    else if (req) n_ack = 1;
    if (n_ack) m_snap = n_pend;
    m_cc = n_cc; m_ack = n_ack; m_await = n_await; m_held = n_held;
    m_pend = n_pend; m_dirty = n_dirty;
  endtask

  task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    exp_rd = cfg_addr ? {m_retry[7:0], 7'd0, m_dirty, 14'd0, enable_ch} : m_pend;
    cmp("model_channel_changed", {31'd0, cc}, {31'd0, m_cc});
    cmp("model_read_ack", {31'd0, ack}, {31'd0, m_ack});
    cmp("model_activate", act, m_snap);
    cmp("model_rdata", cfg_rdata, exp_rd);
    if (cc)  cc_seen++;
    if (ack) ack_seen++;
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (ack !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL %s no read_ack within %0d cycles", name, n);
    end
  endtask

  task automatic wait_cc(input string name, output int n);
    n = 0;
    do begin tick(); n++; end while (cc !== 1'b1 && n < 50);
    checks++;
    if (cc !== 1'b1) begin
      errors++;
      $display("FAIL %s no channel_changed within %0d cycles", name, n);
    end
  endtask

  task automatic write_mask(input logic [31:0] v);
    cfg_addr = 1'b0; cfg_write = 1'b1; cfg_wdata = v;
    tick();
    cfg_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, a1;
    model_reset();
    repeat (3) tick();
    cmp("rst_cc", {31'd0, cc}, 32'd0);
    cmp("rst_ack", {31'd0, ack}, 32'd0);
    cmp("rst_act", act, 32'd0);
    cmp("rst_mask", cfg_rdata, 32'd0);
    cfg_addr = 1'b1; #1;
    cmp("rst_status", cfg_rdata, 32'h0000_0002);
    cfg_addr = 1'b0;
    reset = 1'b0;
    tick();

    // First write: announce two cycles later, then deliver 0x3.
    write_mask(32'h0000_0003);
    cmp("wr_n1_cc", {31'd0, cc}, 32'd0);
    tick();
    cmp("wr_n2_cc", {31'd0, cc}, 32'd1);
    req = 1'b1;
    wait_ack("b_ack");
    cmp("b_act", act, 32'h3);
    req = 1'b0;
    tick(); tick();
    cmp("b_ack_low", {31'd0, ack}, 32'd0);
    cfg_addr = 1'b1; #1;
    cmp("b_status", cfg_rdata, 32'h0000_0002);
    cfg_addr = 1'b0;

    // Upper bits stripped.
    write_mask(32'hFFFF_FFFF);
    cmp("c_mask_rd", cfg_rdata, 32'h3);
    wait_cc("c_cc", n);
    req = 1'b1;
    wait_ack("c_ack");
    cmp("c_act", act, 32'h3);
    req = 1'b0;
    tick(); tick();

    // Two writes fold into one episode; last value wins.
    c0 = cc_seen;
    write_mask(32'h1);
    write_mask(32'h2);
    req = 1'b1;
    wait_ack("d_ack");
    cmp("d_act", act, 32'h2);
    cmp("d_one_pulse", 32'(cc_seen - c0), 32'd1);

    // Write during WAIT_RELEASE; held request must not re-acknowledge.
    tick();
    write_mask(32'h1);
    a1 = ack_seen;
    repeat (4) tick();
    cmp("e_no_reack", 32'(ack_seen - a1), 32'd0);
    cmp("e_no_cc", {31'd0, cc}, 32'd0);
    cfg_addr = 1'b1; #1;
    cmp("e_status_dirty", cfg_rdata, 32'h0001_0002);
    cfg_addr = 1'b0;
    req = 1'b0;
    wait_cc("e_cc", n);
    cmp("e_cc_delay", 32'(n), 32'd2);
    req = 1'b1;
    wait_ack("e_ack");
    cmp("e_act", act, 32'h1);
    req = 1'b0;
    tick(); tick();

    // Write and request together in WAIT_REQ: snapshot takes the new value.
    write_mask(32'h2);
    wait_cc("f_cc", n);
    tick();
    cfg_write = 1'b1; cfg_wdata = 32'h3; req = 1'b1;
    tick();
    cfg_write = 1'b0;
    wait_ack("f_ack");
    cmp("f_act", act, 32'h3);
    req = 1'b0;
    tick(); tick();
    cfg_addr = 1'b1; #1;
    cmp("f_status", cfg_rdata, 32'h0000_0002);

    // Timeout re-pulses every TMO+1 cycles; retry_count counts and saturates.
    write_mask(32'h1);
    cfg_addr = 1'b1;
    wait_cc("g_first", n);
    for (int k = 1; k <= 3; k++) begin
      wait_cc("g_repulse", n);
      cmp("g_period", 32'(n), 32'd5);
      cmp("g_retry", {24'd0, cfg_rdata[31:24]}, 32'(k));
    end
    repeat (260 * 5) tick();
    cmp("g_retry_sat", cfg_rdata, 32'hFF01_0002);

    // Reset during ACK aborts immediately.
    req = 1'b1;
    wait_ack("h_ack");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    cmp("h_ack_drop", {31'd0, ack}, 32'd0);
    cmp("h_act_drop", act, 32'd0);
    req = 1'b0;
    cfg_addr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    c0 = cc_seen;
    repeat (6) tick();
    cmp("h_no_cc", 32'(cc_seen - c0), 32'd0);
    cmp("h_act_zero", act, 32'd0);
    cfg_addr = 1'b1; #1;
    cmp("h_status", cfg_rdata, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
